fifo_index_reader: RTL and testbench

Drain-side consumer for the parameterized synchronous FIFO in the Hamming weight / set-bit index datapath. It pops one word at a time through the FIFO's `rd`/`data_out` read port and computes the word's Hamming weight. It then streams the index of every set bit, lowest first, over a valid/ready interface to the downstream index sink. It is the reader counterpart to the upstream writer that fills the FIFO.

---
 rtl/hw_idx_pkg.sv | 32 +++
 rtl/lsb_prio_enc.sv | 29 ++
 rtl/fifo_index_reader.sv | 108 ++++++++++
 tb/tb_fifo_index_reader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hw_idx_pkg.sv
// Shared types and helpers for the FIFO drain / set-bit index datapath.
// Holds the reader FSM state encoding plus width and popcount helpers.
package hw_idx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        CAPT = 2'd2,
        EMIT = 2'd3
    } rd_state_t;

    // Widest word the popcount helper accepts; narrower words are zero-extended.
    localparam int POPCNT_MAX_W = 256;

    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    function automatic int hw_width(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic int unsigned popcount(input logic [POPCNT_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POPCNT_MAX_W; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/lsb_prio_enc.sv
// Lowest-set-bit priority encoder: position of the least significant 1,
// plus flags for a non-zero vector and a vector with exactly one bit set.
module lsb_prio_enc #(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             one_hot
);

    logic [WIDTH-1:0] w_minus_one;

    // Scan from the top so the lowest set bit is the last (winning) assignment.
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign w_minus_one = vec - WIDTH'(1);
    assign any         = |vec;
    assign one_hot     = any & ~(|(vec & w_minus_one));

endmodule

// File: rtl/fifo_index_reader.sv
// Drains a synchronous FIFO one word at a time, reports each word's Hamming
// weight and streams its set-bit indices (lowest first) over valid/ready.
module fifo_index_reader
    import hw_idx_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDX_W = idx_width(WIDTH),
    parameter int HW_W  = hw_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_emp,
    output logic             fifo_rd,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             hw_valid,
    output logic [HW_W-1:0]  hw,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [IDX_W-1:0] idx,
    output logic             idx_last,
    output logic             busy
);

    rd_state_t        r_state;
    logic [WIDTH-1:0] r_word;
    logic [HW_W-1:0]  r_hw;
    logic             r_hw_valid;
    logic             r_fifo_rd;

    logic [IDX_W-1:0] w_enc_idx;
    logic             w_enc_any;
    logic             w_enc_one;
    logic             w_emit;
    logic             w_hs;
    logic             w_data_nz;

    lsb_prio_enc #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_enc (
        .vec     (r_word),
        .idx     (w_enc_idx),
        .any     (w_enc_any),
        .one_hot (w_enc_one)
    );

    assign w_emit    = (r_state == EMIT);
    assign w_hs      = w_emit & idx_ready;
    assign w_data_nz = |fifo_data;

    // fifo_rd is a flop set on entry to POP so the strobe cannot glitch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_word     <= '0;
            r_hw       <= '0;
            r_hw_valid <= 1'b0;
            r_fifo_rd  <= 1'b0;
        end else begin
            r_hw_valid <= 1'b0;
            r_fifo_rd  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!fifo_emp) begin
                        r_state   <= POP;
                        r_fifo_rd <= 1'b1;
                    end
                end
                POP: begin
                    r_state <= CAPT;
                end
                CAPT: begin
                    r_word     <= fifo_data;
                    r_hw       <= HW_W'(popcount(POPCNT_MAX_W'(fifo_data)));
                    r_hw_valid <= 1'b1;
                    r_state    <= w_data_nz ? EMIT : IDLE;
                end
                EMIT: begin
                    if (!w_enc_any) begin
                        r_state <= IDLE;
                    end else if (w_hs) begin
                        r_word <= r_word & (r_word - WIDTH'(1));
                        if (w_enc_one) begin
                            if (!fifo_emp) begin
                                r_state   <= POP;
                                r_fifo_rd <= 1'b1;
                            end else begin
                                r_state <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign fifo_rd   = r_fifo_rd;
    assign hw_valid  = r_hw_valid;
    assign hw        = r_hw;
    assign idx_valid = w_emit;
    assign idx       = w_emit ? w_enc_idx : '0;
    assign idx_last  = w_emit & w_enc_one;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_fifo_index_reader.sv
// Directed bench for fifo_index_reader: behavioural FIFO in front, scoreboard
// of expected weights/indices filled at push time and drained on handshakes.
module tb_fifo_index_reader;

    localparam int WIDTH = 32;
    localparam int IDX_W = 5;
    localparam int HW_W  = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             fifo_emp = 1'b1;
    logic             fifo_rd;
    logic [WIDTH-1:0] fifo_data = '0;
    logic             hw_valid;
    logic [HW_W-1:0]  hw;
    logic             idx_valid;
    logic             idx_ready = 1'b1;
    logic [IDX_W-1:0] idx;
    logic             idx_last;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rd    = 0;
    bit prev_rd = 1'b0;

    logic [WIDTH-1:0] fq[$];
    int               exp_hw[$];
    int               exp_idx[$];
    bit               exp_last[$];

    fifo_index_reader #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_emp  (fifo_emp),
        .fifo_rd   (fifo_rd),
        .fifo_data (fifo_data),
        .hw_valid  (hw_valid),
        .hw        (hw),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready),
        .idx       (idx),
        .idx_last  (idx_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        int cnt;
        int seen;
        cnt  = $countones(w);
        seen = 0;
        fq.push_back(w);
        fifo_emp = 1'b0;
        exp_hw.push_back(cnt);
        for (int i = 0; i < WIDTH; i++) begin
            if (w[i]) begin
                seen++;
                exp_idx.push_back(i);
                exp_last.push_back(seen == cnt);
            end
        end
    endtask

    task automatic flush_all();
        fq.delete();
        exp_hw.delete();
        exp_idx.delete();
        exp_last.delete();
        fifo_emp  = 1'b1;
        fifo_data = '0;
    endtask

    // Called at the negedge: inputs are settled, so the upcoming edge's
    // handshakes are known. Then advance one cycle and update the FIFO model.
    task automatic tick();
        bit rd_now;
        int e;
        if (rst) begin
            if (hw_valid) begin
                if (exp_hw.size() == 0) chk("hw_unexpected", 64'(hw_valid), 64'd0);
                else begin
                    e = exp_hw.pop_front();
                    chk("hw", 64'(hw), 64'(e));
                end
            end
            if (idx_valid && idx_ready) begin
                if (exp_idx.size() == 0) chk("idx_unexpected", 64'(idx_valid), 64'd0);
                else begin
                    e = exp_idx.pop_front();
                    chk("idx", 64'(idx), 64'(e));
                    chk("idx_last", 64'(idx_last), 64'(exp_last.pop_front()));
                end
            end
            if (!idx_valid) chk("idx_zero_when_invalid", 64'({idx, idx_last}), 64'd0);
            if (fifo_rd) begin
                n_rd++;
                if (prev_rd) chk("rd_back_to_back", 64'(fifo_rd), 64'd0);
            end
        end
        prev_rd = fifo_rd;
        rd_now  = fifo_rd;
        @(posedge clk);
        #1;
        if (rd_now && rst) begin
            if (fq.size() == 0) chk("rd_while_empty", 64'(rd_now), 64'd0);
            else fifo_data = fq.pop_front();
        end
        fifo_emp = (fq.size() == 0);
        @(negedge clk);
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n;
        bit done;
        n = 0;
        while ((busy || fq.size() != 0 || exp_hw.size() != 0 || exp_idx.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        done = !(busy || fq.size() != 0 || exp_hw.size() != 0 || exp_idx.size() != 0);
        chk(tag, 64'(done), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0;
        @(negedge clk);
        tick();
        tick();
        chk("rst_fifo_rd", 64'(fifo_rd), 64'd0);
        chk("rst_hw_valid", 64'(hw_valid), 64'd0);
        chk("rst_hw", 64'(hw), 64'd0);
        chk("rst_idx_valid", 64'(idx_valid), 64'd0);
        chk("rst_idx", 64'({idx, idx_last}), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b1;
        tick();

        // 0x9: latency and two indices
        rd0 = n_rd;
        push_word(32'h0000_0009);
        tick();
        chk("w9_pop_rd", 64'(fifo_rd), 64'd1);
        tick();
        chk("w9_capt_rd", 64'(fifo_rd), 64'd0);
        chk("w9_capt_busy", 64'(busy), 64'd1);
        tick();
        chk("w9_hw_valid", 64'(hw_valid), 64'd1);
        chk("w9_hw", 64'(hw), 64'd2);
        chk("w9_idx_valid", 64'(idx_valid), 64'd1);
        chk("w9_idx0", 64'(idx), 64'd0);
        tick();
        chk("w9_hw_pulse", 64'(hw_valid), 64'd0);
        chk("w9_idx3", 64'(idx), 64'd3);
        chk("w9_last", 64'(idx_last), 64'd1);
        tick();
        chk("w9_idle", 64'(busy), 64'd0);
        chk("w9_hw_hold", 64'(hw), 64'd2);
        chk("w9_one_rd", 64'(n_rd - rd0), 64'd1);
        run_until_idle("w9_done", 20);

        // 0x8000_0000 with backpressure
        idx_ready = 1'b0;
        push_word(32'h8000_0000);
        tick(); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 64'(idx_valid), 64'd1);
            chk("stall_idx", 64'(idx), 64'd31);
            chk("stall_last", 64'(idx_last), 64'd1);
            if (i < 4) tick();
        end
        idx_ready = 1'b1;
        tick();
        chk("stall_idle", 64'(busy), 64'd0);
        run_until_idle("stall_done", 20);

        // zero word
        push_word(32'h0000_0000);
        tick(); tick(); tick();
        chk("zero_hw_valid", 64'(hw_valid), 64'd1);
        chk("zero_hw", 64'(hw), 64'd0);
        chk("zero_no_idx", 64'(idx_valid), 64'd0);
        chk("zero_idle", 64'(busy), 64'd0);
        tick();
        chk("zero_idle2", 64'(busy), 64'd0);
        chk("zero_no_idx2", 64'(idx_valid), 64'd0);
        run_until_idle("zero_done", 20);

        // back-to-back words
        push_word(32'hFFFF_FFFF);
        push_word(32'h0000_0002);
        tick(); tick(); tick();
        chk("ff_hw", 64'(hw), 64'd32);
        for (int i = 0; i < 32; i++) begin
            chk("ff_burst_valid", 64'(idx_valid), 64'd1);
            chk("ff_burst_idx", 64'(idx), 64'(i));
            tick();
        end
        chk("ff_next_rd", 64'(fifo_rd), 64'd1);
        tick(); tick();
        chk("w2_hw", 64'(hw), 64'd1);
        chk("w2_idx", 64'(idx), 64'd1);
        chk("w2_last", 64'(idx_last), 64'd1);
        run_until_idle("w2_done", 20);

        // reset mid-word
        push_word(32'h0000_000F);
        tick(); tick(); tick();
        tick();
        tick();
        chk("rstmid_idx2", 64'(idx), 64'd2);
        rst = 1'b0;
        flush_all();
        tick();
        chk("rstmid_rd", 64'(fifo_rd), 64'd0);
        chk("rstmid_hw_valid", 64'(hw_valid), 64'd0);
        chk("rstmid_hw", 64'(hw), 64'd0);
        chk("rstmid_idx_valid", 64'(idx_valid), 64'd0);
        chk("rstmid_idx", 64'({idx, idx_last}), 64'd0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        fq.push_back(32'h0000_0010);
        fifo_emp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstmid_no_rd", 64'(fifo_rd), 64'd0);
        end
        rst = 1'b1;
        flush_all();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstrel_empty_no_rd", 64'(fifo_rd), 64'd0);
        end
        push_word(32'h0000_0010);
        tick();
        chk("rstrel_rd", 64'(fifo_rd), 64'd1);
        run_until_idle("rstrel_done", 20);

        // long empty stretch
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("empty_rd", 64'(fifo_rd), 64'd0);
            chk("empty_idx_valid", 64'(idx_valid), 64'd0);
            chk("empty_hw_valid", 64'(hw_valid), 64'd0);
        end

        chk("final_exp_idx_drained", 64'(exp_idx.size()), 64'd0);
        chk("final_exp_hw_drained", 64'(exp_hw.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
